// File: rtl/muldiv_if.sv
// Execute-stage request/response bundle for the iterative RV32M multiply/divide unit.
interface muldiv_if #(
    parameter int DATA_WIDTH = 32
);
    logic [1:0]            ALUOp;
    logic [6:0]            Funct7;
    logic [2:0]            Funct3;
    logic                  start;
    logic [DATA_WIDTH-1:0] SrcA;
    logic [DATA_WIDTH-1:0] SrcB;
    logic                  IsMulDiv;
    logic                  Stall;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] Result;

    modport master (
        output ALUOp, Funct7, Funct3, start, SrcA, SrcB,
        input  IsMulDiv, Stall, busy, done, Result
    );

    modport slave (
        input  ALUOp, Funct7, Funct3, start, SrcA, SrcB,
        output IsMulDiv, Stall, busy, done, Result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider on
// operand magnitudes, one bit per cycle, sign applied when the result is registered.
module muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    op;
    logic          neg;
    logic [W-1:0]  opnd;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic [W-1:0]  result_q;
    logic          busy_q;
    logic          done_q;

    logic          accept;
    logic          a_neg, b_neg, neg_acc, special;
    logic [W-1:0]  a_mag, b_mag, special_res;
    logic [W:0]    msum, shifted, trial;
    logic [W-1:0]  nhi, nlo, dval, dval_s, fin;
    logic [2*W-1:0] prod, prod_s;

    assign bus.IsMulDiv = (bus.ALUOp == 2'b10) && (bus.Funct7 == 7'b0000001);
    assign accept       = bus.start && bus.IsMulDiv && (state != BUSY);
    assign bus.Stall    = busy_q || accept;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.Result   = result_q;

    // Operand preparation and special-case detection for the accept edge.
    always_comb begin
        a_neg = 1'b0;
        b_neg = 1'b0;
        case (bus.Funct3)
            3'b001:         begin a_neg = bus.SrcA[W-1]; b_neg = bus.SrcB[W-1]; end
            3'b010:         a_neg = bus.SrcA[W-1];
            3'b100, 3'b110: begin a_neg = bus.SrcA[W-1]; b_neg = bus.SrcB[W-1]; end
            default:        ;
        endcase
        a_mag   = a_neg ? -bus.SrcA : bus.SrcA;
        b_mag   = b_neg ? -bus.SrcB : bus.SrcB;
        neg_acc = (bus.Funct3[2] && bus.Funct3[1]) ? a_neg : (a_neg ^ b_neg);

        special     = 1'b0;
        special_res = '0;
        if (bus.Funct3[2] && (bus.SrcB == '0)) begin
            special     = 1'b1;
            special_res = bus.Funct3[1] ? bus.SrcA : '1;
        end else if (bus.Funct3[2] && !bus.Funct3[0] && (bus.SrcA == MINV) && (bus.SrcB == '1)) begin
            special     = 1'b1;
            special_res = bus.Funct3[1] ? '0 : bus.SrcA;
        end
    end

    // One iteration step; the final result is formed from the post-step values so it
    // can be registered on the same edge as the last iteration.
    always_comb begin
        msum    = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        shifted = {hi, lo[W-1]};
        trial   = shifted - {1'b0, opnd};
        if (op[2]) begin
            if (!trial[W]) begin
                nhi = trial[W-1:0];
                nlo = {lo[W-2:0], 1'b1};
            end else begin
                nhi = shifted[W-1:0];
                nlo = {lo[W-2:0], 1'b0};
            end
        end else begin
            nhi = msum[W:1];
            nlo = {msum[0], lo[W-1:1]};
        end
        prod   = {nhi, nlo};
        prod_s = neg ? -prod : prod;
        dval   = op[1] ? nhi : nlo;
        dval_s = neg ? -dval : dval;
        if (op[2])
            fin = dval_s;
        else if (op[1:0] == 2'b00)
            fin = prod_s[W-1:0];
        else
            fin = prod_s[2*W-1:W];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            op       <= '0;
            neg      <= 1'b0;
            opnd     <= '0;
            hi       <= '0;
            lo       <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                    if (accept) begin
                        op  <= bus.Funct3;
                        neg <= neg_acc;
                        cnt <= '0;
                        if (special) begin
                            result_q <= special_res;
                            done_q   <= 1'b1;
                            state    <= DONE;
                        end else begin
                            // Multiply: lo holds the multiplier; divide: lo holds the dividend.
                            opnd   <= bus.Funct3[2] ? b_mag : a_mag;
                            lo     <= bus.Funct3[2] ? a_mag : b_mag;
                            hi     <= '0;
                            busy_q <= 1'b1;
                            state  <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    hi  <= nhi;
                    lo  <= nlo;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(W-1)) begin
                        result_q <= fin;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: issued operations push reference results, a
// monitor pops and compares on every done pulse.
module tb_muldiv_unit;
    localparam int W = 32;

    typedef struct {
        logic [31:0] res;
        int          due;
        logic [2:0]  f3;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t scb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    muldiv_if #(.DATA_WIDTH(W)) bus ();
    muldiv_unit #(.DATA_WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: plain 64-bit products and language division/remainder.
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b, output bit special);
        logic signed [63:0] sa, sb, ua, ub, p;
        logic [31:0] r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        special = 1'b0;
        r = '0;
        case (f3)
            3'd0: begin p = ua * ub; r = p[31:0];  end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin
                if (b == 0) begin special = 1'b1; r = 32'hFFFF_FFFF; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin special = 1'b1; r = a; end
                else r = $signed(a) / $signed(b);
            end
            3'd5: begin
                if (b == 0) begin special = 1'b1; r = 32'hFFFF_FFFF; end
                else r = a / b;
            end
            3'd6: begin
                if (b == 0) begin special = 1'b1; r = a; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin special = 1'b1; r = 0; end
                else r = $signed(a) % $signed(b);
            end
            default: begin
                if (b == 0) begin special = 1'b1; r = a; end
                else r = a % b;
            end
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.done) begin
            if (scb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = scb.pop_front();
                check($sformatf("result_f3_%0d", e.f3), bus.Result, e.res);
                check($sformatf("latency_f3_%0d", e.f3), cyc, e.due);
            end
        end
    end

    task automatic wait_not_busy();
        int n = 0;
        while (bus.busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.busy) check("busy_timeout", 32'd1, 32'd0);
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bit sp;
        logic [31:0] r;
        wait_not_busy();
        bus.ALUOp  = 2'b10;
        bus.Funct7 = 7'b0000001;
        bus.Funct3 = f3;
        bus.SrcA   = a;
        bus.SrcB   = b;
        bus.start  = 1'b1;
        r = model(f3, a, b, sp);
        scb.push_back('{r, cyc + (sp ? 1 : 33), f3});
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.SrcA   = $urandom;
        bus.SrcB   = $urandom;
        bus.Funct3 = 3'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (scb.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (scb.size() != 0) check("drain_timeout", 32'(scb.size()), 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n, stall_cnt;
        bit sp;
        logic [31:0] r;

        reset      = 1'b1;
        bus.ALUOp  = 2'b00;
        bus.Funct7 = '0;
        bus.Funct3 = '0;
        bus.start  = 1'b0;
        bus.SrcA   = '0;
        bus.SrcB   = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_result", bus.Result, 32'h0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_stall", 32'(bus.Stall), 32'd0);

        // MUL 7 x -3 with Stall profile across the whole operation.
        bus.ALUOp  = 2'b10;
        bus.Funct7 = 7'b0000001;
        bus.Funct3 = 3'd0;
        bus.SrcA   = 32'd7;
        bus.SrcB   = 32'hFFFF_FFFD;
        bus.start  = 1'b1;
        scb.push_back('{32'hFFFF_FFEB, cyc + 33, 3'd0});
        #1;
        stall_cnt = bus.Stall ? 1 : 0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.SrcA  = $urandom;
        bus.SrcB  = $urandom;
        n = 1;
        while (!bus.done && n < 60) begin
            if (bus.Stall) stall_cnt++;
            @(posedge clk); #1;
            n++;
        end
        check("mul_done_cycle", 32'(n), 32'd33);
        check("mul_stall_cycles", 32'(stall_cnt), 32'd33);
        check("mul_stall_on_done", 32'(bus.Stall), 32'd0);

        issue(3'd1, 32'h8000_0000, 32'h8000_0000);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'd2, 32'hFFFF_FFFF, 32'd2);
        issue(3'd5, 32'd100, 32'd7);
        issue(3'd7, 32'd100, 32'd7);
        issue(3'd4, -32'sd100, 32'd7);
        issue(3'd6, -32'sd100, 32'd7);
        issue(3'd4, 32'd5, 32'd0);
        issue(3'd7, 32'd5, 32'd0);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        drain();

        // Back-to-back: start held through BUSY and the DONE cycle.
        issue(3'd5, 32'd1000, 32'd37);
        bus.Funct3 = 3'd0;
        bus.SrcA   = 32'd12345;
        bus.SrcB   = 32'd678;
        bus.start  = 1'b1;
        n = 0;
        while (!bus.done && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.done) check("b2b_timeout", 32'd1, 32'd0);
        r = model(3'd0, 32'd12345, 32'd678, sp);
        scb.push_back('{r, cyc + 33, 3'd0});
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("b2b_done_drops", 32'(bus.done), 32'd0);
        check("b2b_busy", 32'(bus.busy), 32'd1);
        drain();
        @(posedge clk); #1;

        // Non-M instruction with start is ignored.
        bus.ALUOp  = 2'b10;
        bus.Funct7 = 7'b0000000;
        bus.start  = 1'b1;
        #1;
        check("ignore_ismuldiv", 32'(bus.IsMulDiv), 32'd0);
        check("ignore_stall", 32'(bus.Stall), 32'd0);
        @(posedge clk); #1;
        check("ignore_busy", 32'(bus.busy), 32'd0);
        check("ignore_done", 32'(bus.done), 32'd0);
        bus.start = 1'b0;

        // Reset aborts an operation ten cycles in.
        issue(3'd0, 32'd123, 32'd456);
        repeat (9) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        scb.delete();
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_result", bus.Result, 32'h0);
        repeat (40) begin @(posedge clk); #1; end
        issue(3'd5, 32'd9, 32'd3);
        drain();

        for (int i = 0; i < 60; i++) begin
            issue(3'($urandom_range(0, 7)), pick(), pick());
            if ($urandom_range(0, 3) == 0) begin
                wait_not_busy();
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            end
        end
        drain();
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
